// File: rtl/axi_test_sw_debounce.sv
// Slide-switch conditioner: a 2-FF synchronizer and a per-bit stability counter.
// Produces a clean registered level plus one-cycle rise/fall/changed strobes.
module axi_test_sw_debounce #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 1000000,  // >= 2
  parameter int               CNT_W           = 20,       // 2**CNT_W > DEBOUNCE_CYCLES-1
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_sw_db;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_changed;
  logic [CNT_W-1:0] r_cnt [WIDTH];

  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_accept;

  // A bit is accepted on the edge where its mismatch has already lasted
  // DEBOUNCE_CYCLES-1 edges, so this edge is the DEBOUNCE_CYCLES-th.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_diff   = r_sync2 ^ r_sw_db;
    w_accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_accept[i] = w_diff[i] && (r_cnt[i] == C_LAST);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_sync1   <= RESET_VAL;
      r_sync2   <= RESET_VAL;
      r_sw_db   <= RESET_VAL;
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
      // NOTE: the counter array is a handful of flops, not a RAM, so resetting every entry is cheap and required.
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1   <= sw_raw;
      r_sync2   <= r_sync1;
      r_sw_db   <= (r_sw_db & ~w_accept) | (r_sync2 & w_accept);
      r_rise    <= w_accept & r_sync2;
      r_fall    <= w_accept & ~r_sync2;
      r_changed <= |w_accept;
      // Any return to the accepted level restarts timing; acceptance also clears.
      for (int i = 0; i < WIDTH; i++) begin
        if (!w_diff[i] || w_accept[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign sw_db   = r_sw_db;
  assign rise    = r_rise;
  assign fall    = r_fall;
  assign changed = r_changed;

endmodule

// File: tb/tb_axi_test_sw_debounce.sv
// Directed bench for axi_test_sw_debounce (DEBOUNCE_CYCLES=8): expected strobe
// events are queued when stimulus is applied and checked when the DUT pulses.
module tb_axi_test_sw_debounce;

  localparam int LAT = 10;  // edges from an input change to the accepted strobe

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sw_raw = 4'hF;
  logic [3:0] sw_db;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       changed;

  typedef struct {
    int         cyc;
    logic [3:0] db;
    logic [3:0] rs;
    logic [3:0] fl;
    logic       chg;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   errs = 0;
  int   max_cnt = 0;

  axi_test_sw_debounce #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(8),
    .CNT_W          (4),
    .RESET_VAL      (4'h0)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sw_raw (sw_raw),
    .sw_db  (sw_db),
    .rise   (rise),
    .fall   (fall),
    .changed(changed)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t required < 500000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_pulse(input int at, input logic [3:0] db, input logic [3:0] rs,
                              input logic [3:0] fl);
    exp_t e;
    e.cyc = at;
    e.db  = db;
    e.rs  = rs;
    e.fl  = fl;
    e.chg = (rs | fl) != 4'h0;
    sb.push_back(e);
  endtask

  // Advance one rising edge, then inspect outputs on the following falling edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (int'(dut.r_cnt[i]) > max_cnt) max_cnt = int'(dut.r_cnt[i]);
    end
    if (rise !== 4'h0 || fall !== 4'h0 || changed !== 1'b0) begin
      vectors++;
      assert (sb.size() > 0) else begin
        errs++;
        $error("FAIL unexpected_strobe: observed cyc=%0d rise=%h fall=%h changed=%b sw_db=%h expected no strobe",
               cyc, rise, fall, changed, sw_db);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("strobe_event", {cyc[15:0], sw_db, rise, fall, 3'b000, changed},
              {e.cyc[15:0], e.db, e.rs, e.fl, 3'b000, e.chg});
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain(input string tag);
    check(tag, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    int k;

    // 1: reset held 3 edges with all switches high, then release.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_sw_db", {28'd0, sw_db}, 32'h0);
      check("reset_strobes", {23'd0, rise, fall, changed}, 32'h0);
    end
    reset = 1'b0;
    expect_pulse(cyc + LAT, 4'hF, 4'hF, 4'h0);
    ticks(LAT - 1);
    check("pre_accept_sw_db", {28'd0, sw_db}, 32'h0);
    ticks(3);
    drain("reset_release_pulse");
    check("post_reset_sw_db", {28'd0, sw_db}, 32'hF);

    // Return to all-low.
    sw_raw = 4'h0;
    expect_pulse(cyc + LAT, 4'h0, 4'h0, 4'hF);
    ticks(LAT + 2);
    drain("all_fall_pulse");

    // 2: 6-cycle glitch on bit0 is rejected.
    sw_raw = 4'h1;
    ticks(6);
    sw_raw = 4'h0;
    ticks(20);
    drain("glitch_none");
    check("glitch_sw_db", {28'd0, sw_db}, 32'h0);

    // 3: bit1 bounces, then settles high.
    sw_raw = 4'h2; ticks(2);
    sw_raw = 4'h0; ticks(2);
    sw_raw = 4'h2; ticks(2);
    sw_raw = 4'h0; ticks(2);
    sw_raw = 4'h2;
    expect_pulse(cyc + LAT, 4'h2, 4'h2, 4'h0);
    ticks(LAT + 4);
    drain("bounce_single_rise");
    check("bounce_sw_db", {28'd0, sw_db}, 32'h2);

    // 4: reach 8, then swap 8->4 so two bits update on one edge.
    sw_raw = 4'h8;
    expect_pulse(cyc + LAT, 4'h8, 4'h8, 4'h2);
    ticks(LAT + 2);
    drain("to_8_pulse");
    sw_raw = 4'h4;
    expect_pulse(cyc + LAT, 4'h4, 4'h4, 4'h8);
    ticks(LAT + 2);
    drain("simultaneous_pulse");

    // 5: raise bit0, reset for one edge once its counter reaches 5.
    sw_raw = 4'h5;
    ticks(7);
    check("cnt0_before_reset", {28'd0, dut.r_cnt[0]}, 32'd5);
    reset = 1'b1;
    tick();
    check("midcount_reset_sw_db", {28'd0, sw_db}, 32'h0);
    reset = 1'b0;
    expect_pulse(cyc + LAT, 4'h5, 4'h5, 4'h0);
    ticks(LAT + 2);
    drain("after_midcount_reset");
    check("midcount_sw_db", {28'd0, sw_db}, 32'h5);

    // 6: bit2 low for 7 edges at sync2 is rejected; 8 edges is accepted,
    // and the immediate return high counts again with no dead time.
    sw_raw = 4'h1; ticks(7);
    sw_raw = 4'h5; ticks(12);
    drain("threshold_7_rejected");
    check("threshold_7_sw_db", {28'd0, sw_db}, 32'h5);
    k = cyc;
    sw_raw = 4'h1;
    expect_pulse(k + LAT, 4'h1, 4'h0, 4'h4);
    ticks(8);
    sw_raw = 4'h5;
    expect_pulse(k + 8 + LAT, 4'h5, 4'h4, 4'h0);
    ticks(LAT + 2);
    drain("threshold_8_accepted");
    check("threshold_sw_db", {28'd0, sw_db}, 32'h5);
    check("max_counter", 32'(max_cnt), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
